// File: rtl/pmm_dispatcher.sv
// pmm_dispatcher: round-robin job scheduler in front of N_PMM matchers.
// Optional PMM_STATS_EN adds saturating job_count/match_count outputs.
module pmm_dispatcher #(
  parameter int N_PMM       = 4,
  parameter int DATA_W      = 64,
  parameter int CTRL_W      = 16,
  parameter int TAG_W       = 8,
  parameter int RESULT_WAIT = 4,
  localparam int ID_W = (N_PMM > 1) ? $clog2(N_PMM) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [TAG_W-1:0]        in_tag,
  output logic [N_PMM*DATA_W-1:0] pmm_data,
  output logic [N_PMM*CTRL_W-1:0] pmm_ctrl,
  output logic [N_PMM-1:0]        pmm_valid,
  input  logic [N_PMM-1:0]        pmm_ready,
  input  logic [N_PMM-1:0]        pmm_accepted,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [TAG_W-1:0]        res_tag,
  output logic [ID_W-1:0]         res_id,
  output logic                    res_match,
  output logic [N_PMM-1:0]        busy
`ifdef PMM_STATS_EN
  ,
  output logic [31:0]             job_count,
  output logic [31:0]             match_count
`endif
);

  localparam int CNT_W = (RESULT_WAIT > 0) ? $clog2(RESULT_WAIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, REPORT} st_t;

  st_t              st   [N_PMM];
  logic [CNT_W-1:0] cnt  [N_PMM];
  logic [TAG_W-1:0] tag  [N_PMM];
  logic [N_PMM-1:0] match;
  logic [N_PMM-1:0] idle;

  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic [CTRL_W-1:0] hold_ctrl;
  logic [ID_W-1:0]   hold_id;
  logic              job_open;
  logic [ID_W-1:0]   cur;
  logic [ID_W-1:0]   alloc_rr;
  logic [ID_W-1:0]   res_rr;

  logic            fire, last_fire, acc, alloc_go;
  logic            alloc_found, res_found, res_load;
  logic [ID_W-1:0] alloc_id, res_sel, target;

  // Handshake decode around the single-beat hold register
  always_comb begin
    for (int i = 0; i < N_PMM; i++) idle[i] = (st[i] == IDLE);
    busy      = ~idle;
    fire      = hold_full & pmm_ready[hold_id];
    last_fire = fire & hold_ctrl[CTRL_W-1];
    in_ready  = (!hold_full | fire) & (job_open | (|idle));
    acc       = in_valid & in_ready;
    alloc_go  = acc & !job_open;
    target    = job_open ? cur : alloc_id;
  end

  // Round-robin pickers: first IDLE after alloc_rr, first REPORT after res_rr
  always_comb begin
    int a_idx;
    int r_idx;
    a_idx       = 0;
    r_idx       = 0;
    alloc_found = 1'b0;
    alloc_id    = '0;
    res_found   = 1'b0;
    res_sel     = '0;
    for (int k = N_PMM; k >= 1; k--) begin
      a_idx = (int'(alloc_rr) + k) % N_PMM;
      r_idx = (int'(res_rr) + k) % N_PMM;
      if (idle[a_idx]) begin
        alloc_found = 1'b1;
        alloc_id    = ID_W'(a_idx);
      end
      if (st[r_idx] == REPORT) begin
        res_found = 1'b1;
        res_sel   = ID_W'(r_idx);
      end
    end
    res_load = res_found & (!res_valid | res_ready);
  end

  // Hold register contents appear only on the targeted PMM slice
  always_comb begin
    pmm_data  = '0;
    pmm_ctrl  = '0;
    pmm_valid = '0;
    if (hold_full) begin
      pmm_data[hold_id*DATA_W +: DATA_W] = hold_data;
      pmm_ctrl[hold_id*CTRL_W +: CTRL_W] = hold_ctrl;
      pmm_valid[hold_id]                 = 1'b1;
    end
  end

  // Hold register load/drain and job framing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_ctrl <= '0;
      hold_id   <= '0;
      job_open  <= 1'b0;
      cur       <= '0;
      alloc_rr  <= ID_W'(N_PMM - 1);
    end else begin
      if (acc) begin
        hold_full <= 1'b1;
        hold_data <= in_data;
        hold_ctrl <= in_ctrl;
        hold_id   <= target;
        job_open  <= !in_ctrl[CTRL_W-1];
      end else if (fire) begin
        hold_full <= 1'b0;
      end
      if (alloc_go && alloc_found) begin
        cur      <= alloc_id;
        alloc_rr <= alloc_id;
      end
    end
  end

  // Per-PMM job FSMs and the shared result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PMM; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
        tag[i] <= '0;
      end
      match     <= '0;
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_id    <= '0;
      res_match <= 1'b0;
      res_rr    <= ID_W'(N_PMM - 1);
`ifdef PMM_STATS_EN
      job_count   <= '0;
      match_count <= '0;
`endif
    end else begin
      for (int i = 0; i < N_PMM; i++) begin
        unique case (st[i])
          IDLE: begin
            if (alloc_go && alloc_found && alloc_id == ID_W'(i)) begin
              st[i]  <= STREAM;
              tag[i] <= in_tag;
            end
          end
          STREAM: begin
            if (last_fire && hold_id == ID_W'(i)) begin
              st[i]  <= WAIT;
              cnt[i] <= CNT_W'(RESULT_WAIT);
            end
          end
          WAIT: begin
            if (cnt[i] == '0) begin
              match[i] <= pmm_accepted[i];
              st[i]    <= REPORT;
            end else begin
              cnt[i] <= cnt[i] - CNT_W'(1);
            end
          end
          REPORT: begin
            if (res_load && res_sel == ID_W'(i)) st[i] <= IDLE;
          end
        endcase
      end
      if (res_load) begin
        res_valid <= 1'b1;
        res_tag   <= tag[res_sel];
        res_id    <= res_sel;
        res_match <= match[res_sel];
        res_rr    <= res_sel;
`ifdef PMM_STATS_EN
        if (job_count != 32'hFFFF_FFFF) job_count <= job_count + 32'd1;
        if (match[res_sel] && match_count != 32'hFFFF_FFFF)
          match_count <= match_count + 32'd1;
`endif
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pmm_dispatcher.sv
// tb_pmm_dispatcher: directed scenarios for pmm_dispatcher.
// Build with +define+PMM_STATS_EN to include the counter scenario.
module tb_pmm_dispatcher;

  localparam int N = 4;
  localparam int DW = 64;
  localparam int CW = 16;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic [TW-1:0] in_tag = '0;
  logic [N*DW-1:0] pmm_data;
  logic [N*CW-1:0] pmm_ctrl;
  logic [N-1:0]  pmm_valid;
  logic [N-1:0]  pmm_ready = '1;
  logic [N-1:0]  pmm_accepted = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [TW-1:0] res_tag;
  logic [1:0]    res_id;
  logic          res_match;
  logic [N-1:0]  busy;
`ifdef PMM_STATS_EN
  logic [31:0]   job_count;
  logic [31:0]   match_count;
`endif

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] flog_d[$];
  int            flog_id[$];

  pmm_dispatcher dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_tag(in_tag),
    .pmm_data(pmm_data), .pmm_ctrl(pmm_ctrl),
    .pmm_valid(pmm_valid), .pmm_ready(pmm_ready),
    .pmm_accepted(pmm_accepted),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_tag(res_tag), .res_id(res_id), .res_match(res_match),
    .busy(busy)
`ifdef PMM_STATS_EN
    , .job_count(job_count), .match_count(match_count)
`endif
  );

  always #5 clk = ~clk;

  // Log every beat delivered to a PMM
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (pmm_valid[i] && pmm_ready[i]) begin
          flog_d.push_back(pmm_data[i*DW +: DW]);
          flog_id.push_back(i);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d,
                           input logic [CW-1:0] c,
                           input logic [TW-1:0] t);
    logic done;
    int   n;
    in_valid = 1'b1;
    in_data = d;
    in_ctrl = c;
    in_tag = t;
    done = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      #1;
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL send_timeout: tag %h never accepted", t);
    end
  endtask

  task automatic wait_res;
    int n;
    n = 0;
    while (!res_valid && n < 40) begin
      step();
      n++;
    end
    compared++;
    if (!res_valid) begin
      mismatched++;
      $display("FAIL res_timeout: res_valid=0 want 1");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (pmm_valid !== 4'b0) begin
      mismatched++; $display("FAIL rst_pmm_valid: got %b want 0000", pmm_valid);
    end
    compared++;
    if (pmm_data !== '0 || pmm_ctrl !== '0) begin
      mismatched++; $display("FAIL rst_pmm_data: got %h want 0", pmm_data);
    end
    compared++;
    if (res_valid !== 1'b0 || res_tag !== 8'h00 ||
        res_id !== 2'd0 || res_match !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_res: got v%b t%h i%0d m%b want all 0",
               res_valid, res_tag, res_id, res_match);
    end
    compared++;
    if (busy !== 4'b0) begin
      mismatched++; $display("FAIL rst_busy: got %b want 0000", busy);
    end
    rst = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++; $display("FAIL rst_in_ready: got %b want 1", in_ready);
    end
    // reset in the middle of a job
    pmm_ready = '1;
    pmm_accepted = '1;
    send_beat(64'h1, 16'h0000, 8'h77);
    send_beat(64'h2, 16'h0000, 8'hFF);
    compared++;
    if (busy !== 4'b0001) begin
      mismatched++; $display("FAIL mid_busy: got %b want 0001", busy);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (pmm_valid !== 4'b0 || busy !== 4'b0 || res_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_rst: got pv%b b%b rv%b want 0",
               pmm_valid, busy, res_valid);
    end
    step();
    rst = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++; $display("FAIL mid_in_ready: got %b want 1", in_ready);
    end
    send_beat(64'h3, 16'h8000, 8'h88);
    compared++;
    if (pmm_valid !== 4'b0001) begin
      mismatched++; $display("FAIL mid_alloc: got %b want 0001", pmm_valid);
    end
    wait_res();
    compared++;
    if (res_tag !== 8'h88 || res_id !== 2'd0) begin
      mismatched++;
      $display("FAIL mid_res: got t%h i%0d want t88 i0", res_tag, res_id);
    end
  endtask

  task automatic test_single_job;
    do_reset();
    pmm_ready = '1;
    pmm_accepted = 4'b0001;
    send_beat(64'hD1, 16'h0001, 8'h5A);
    compared++;
    if (pmm_valid !== 4'b0001 || pmm_data !== {192'b0, 64'hD1}) begin
      mismatched++;
      $display("FAIL single_b1: got pv%b d%h want 0001 d1", pmm_valid, pmm_data);
    end
    send_beat(64'hD2, 16'h0002, 8'hFF);
    compared++;
    if (pmm_valid !== 4'b0001 || pmm_data !== {192'b0, 64'hD2}) begin
      mismatched++;
      $display("FAIL single_b2: got pv%b d%h want 0001 d2", pmm_valid, pmm_data);
    end
    send_beat(64'hD3, 16'h8003, 8'hEE);
    compared++;
    if (pmm_ctrl !== {48'b0, 16'h8003} || busy !== 4'b0001) begin
      mismatched++;
      $display("FAIL single_b3: got c%h b%b want 8003 0001", pmm_ctrl, busy);
    end
    // LAST fires on the next edge; sample 5 edges later, result 1 edge after
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) begin
        compared++;
        if (res_valid !== 1'b0) begin
          mismatched++; $display("FAIL single_early: got %b want 0", res_valid);
        end
      end
      if (k == 7) begin
        compared++;
        if (res_valid !== 1'b1) begin
          mismatched++; $display("FAIL single_lat: got %b want 1", res_valid);
        end
      end
    end
    compared++;
    if (res_tag !== 8'h5A || res_id !== 2'd0 || res_match !== 1'b1) begin
      mismatched++;
      $display("FAIL single_res: got t%h i%0d m%b want 5a 0 1",
               res_tag, res_id, res_match);
    end
    repeat (3) step();
    compared++;
    if (res_valid !== 1'b1 || res_tag !== 8'h5A) begin
      mismatched++;
      $display("FAIL single_hold: got v%b t%h want 1 5a", res_valid, res_tag);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    compared++;
    if (res_valid !== 1'b0 || busy !== 4'b0) begin
      mismatched++;
      $display("FAIL single_drain: got v%b b%b want 0 0000", res_valid, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] exp_pv;
    do_reset();
    pmm_ready = '1;
    pmm_accepted = '0;
    for (int j = 0; j < 4; j++) begin
      send_beat(64'h100 + 64'(j), 16'h8000, 8'h10 + 8'(j));
      exp_pv = 4'b0001 << j;
      compared++;
      if (pmm_valid !== exp_pv) begin
        mismatched++;
        $display("FAIL b2b_alloc%0d: got %b want %b", j, pmm_valid, exp_pv);
      end
    end
    in_valid = 1'b1;
    in_data = 64'h104;
    in_ctrl = 16'h8000;
    in_tag = 8'h14;
    #1;
    compared++;
    if (in_ready !== 1'b0 || busy !== 4'b1111) begin
      mismatched++;
      $display("FAIL b2b_full: got r%b b%b want 0 1111", in_ready, busy);
    end
    send_beat(64'h104, 16'h8000, 8'h14);
    compared++;
    if (pmm_valid !== 4'b0001 || pmm_data[63:0] !== 64'h104) begin
      mismatched++;
      $display("FAIL b2b_freed: got pv%b d%h want 0001 104",
               pmm_valid, pmm_data[63:0]);
    end
    compared++;
    if (res_valid !== 1'b1 || res_tag !== 8'h10 || res_id !== 2'd0) begin
      mismatched++;
      $display("FAIL b2b_res: got v%b t%h i%0d want 1 10 0",
               res_valid, res_tag, res_id);
    end
  endtask

  task automatic test_stall;
    int base;
    do_reset();
    pmm_ready = '1;
    pmm_accepted = '0;
    res_ready = 1'b1;
    send_beat(64'hAAAA, 16'h8000, 8'h20);
    repeat (2) step();
    base = flog_d.size();
    send_beat(64'hB1, 16'h0000, 8'h21);
    compared++;
    if (pmm_valid !== 4'b0010) begin
      mismatched++; $display("FAIL stall_alloc: got %b want 0010", pmm_valid);
    end
    send_beat(64'hB2, 16'h0000, 8'hFF);
    pmm_ready = 4'b1101;
    in_valid = 1'b1;
    in_data = 64'hB3;
    in_ctrl = 16'h8000;
    in_tag = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      step();
      compared++;
      if (pmm_valid !== 4'b0010 || pmm_data[127:64] !== 64'hB2 ||
          in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_hold%0d: got pv%b d%h r%b want 0010 b2 0",
                 k, pmm_valid, pmm_data[127:64], in_ready);
      end
    end
    pmm_ready = '1;
    step();
    in_valid = 1'b0;
    compared++;
    if (pmm_data[127:64] !== 64'hB3 || pmm_ctrl[31:16] !== 16'h8000) begin
      mismatched++;
      $display("FAIL stall_b3: got d%h c%h want b3 8000",
               pmm_data[127:64], pmm_ctrl[31:16]);
    end
    repeat (2) step();
    compared++;
    if (flog_d.size() - base != 3) begin
      mismatched++;
      $display("FAIL stall_count: got %0d want 3", flog_d.size() - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (flog_d[base+k] !== 64'hB1 + 64'(k) || flog_id[base+k] != 1) begin
          mismatched++;
          $display("FAIL stall_seq%0d: got pmm%0d %h want pmm1 %h",
                   k, flog_id[base+k], flog_d[base+k], 64'hB1 + 64'(k));
        end
      end
    end
  endtask

  task automatic test_result_rr;
    logic [TW-1:0] et[3];
    logic [1:0]    ei[3];
    logic          em[3];
    et = '{8'hA2, 8'hA3, 8'hA4};
    ei = '{2'd2, 2'd3, 2'd0};
    em = '{1'b1, 1'b0, 1'b1};
    do_reset();
    pmm_ready = '1;
    pmm_accepted = 4'b0110;
    for (int j = 0; j < 4; j++) send_beat(64'(j), 16'h8000, 8'hA0 + 8'(j));
    wait_res();
    compared++;
    if (res_tag !== 8'hA0 || res_id !== 2'd0 || res_match !== 1'b0) begin
      mismatched++;
      $display("FAIL rr_first: got t%h i%0d m%b want a0 0 0",
               res_tag, res_id, res_match);
    end
    repeat (8) step();
    compared++;
    if (busy !== 4'b1110) begin
      mismatched++; $display("FAIL rr_busy: got %b want 1110", busy);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    compared++;
    if (res_tag !== 8'hA1 || res_id !== 2'd1 || res_match !== 1'b1) begin
      mismatched++;
      $display("FAIL rr_second: got t%h i%0d m%b want a1 1 1",
               res_tag, res_id, res_match);
    end
    pmm_accepted = 4'b0111;
    send_beat(64'h4, 16'h8000, 8'hA4);
    compared++;
    if (pmm_valid !== 4'b0001) begin
      mismatched++; $display("FAIL rr_realloc: got %b want 0001", pmm_valid);
    end
    repeat (8) step();
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      compared++;
      if (res_valid !== 1'b1 || res_tag !== et[k] ||
          res_id !== ei[k] || res_match !== em[k]) begin
        mismatched++;
        $display("FAIL rr_order%0d: got v%b t%h i%0d m%b want 1 %h %0d %b",
                 k, res_valid, res_tag, res_id, res_match, et[k], ei[k], em[k]);
      end
    end
    step();
    res_ready = 1'b0;
    compared++;
    if (res_valid !== 1'b0) begin
      mismatched++; $display("FAIL rr_empty: got %b want 0", res_valid);
    end
  endtask

`ifdef PMM_STATS_EN
  task automatic test_stats;
    logic [5:0] mv;
    mv = 6'b101011;
    do_reset();
    pmm_ready = '1;
    res_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      pmm_accepted = mv[j] ? 4'b1111 : 4'b0000;
      send_beat(64'(j), 16'h8000, 8'(j));
      wait_res();
      step();
    end
    compared++;
    if (job_count !== 32'd6 || match_count !== 32'd4) begin
      mismatched++;
      $display("FAIL stats: got jobs %0d matches %0d want 6 4",
               job_count, match_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_stall();
    test_result_rr();
`ifdef PMM_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
